router_param: RTL and testbench

Parameterised 5-port mesh router for the NoC: per-input FIFOs, XY route computation, per-output round-robin switch allocation with wormhole locking, and per-output credit-based flow control. It replaces the fixed 20-bit, single-flit router with configurable flit width, buffer depth, credit depth and mesh size. It sits at every mesh node between four neighbour links and the local network interface.

---
 rtl/router_param_if.sv | 22 ++
 rtl/router_param.sv | 203 ++++++++++++++++++++
 tb/tb_router_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_param_if.sv
// Flat 5-port flit/credit bundle between a router and its neighbours.
// master drives flits in and credits back; slave is the router side.
interface router_param_if #(
    parameter int FLIT_W = 22
);
    logic [5*FLIT_W-1:0] in_flit;
    logic [4:0]          in_valid;
    logic [4:0]          in_credit_out;
    logic [5*FLIT_W-1:0] out_flit;
    logic [4:0]          out_valid;
    logic [4:0]          out_credit_in;

    modport master (
        output in_flit, in_valid, out_credit_in,
        input  in_credit_out, out_flit, out_valid
    );

    modport slave (
        input  in_flit, in_valid, out_credit_in,
        output in_credit_out, out_flit, out_valid
    );
endinterface

// File: rtl/router_param.sv
// router_param: 5-port XY mesh router, per-input FIFOs, round-robin wormhole allocation; ROUTER_ERR_EN enables sticky err.
// Latency: one cycle from input write to registered out_flit/out_valid; in_credit_out pulses with out_valid.
// Backpressure: zero credit stalls an output (locks held); writes into a full FIFO are dropped.
module router_param #(
    parameter int DATA_W     = 16,
    parameter int COORD_W    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    router_param_if.slave      ports,
    output logic [9:0]         err
);
    localparam int NP     = 5;
    localparam int FLIT_W = DATA_W + 2*COORD_W + 2;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(CREDITS + 1);

    typedef logic [FLIT_W-1:0] flit_t;

    flit_t         mem_q    [NP][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q [NP];
    logic [AW-1:0] rd_ptr_q [NP];
    logic [AW:0]   cnt_q    [NP];
    flit_t         front    [NP];
    logic [NP-1:0] empty;
    logic [NP-1:0] full;
    logic [NP-1:0] wr_en;
    logic [NP-1:0] pop;
    logic [NP-1:0] owns;
    logic [NP-1:0] req      [NP];

    logic [NP-1:0] lock_q;
    logic [NP-1:0] lock_d;
    logic [2:0]    owner_q  [NP];
    logic [2:0]    owner_d  [NP];
    logic [2:0]    rr_q     [NP];
    logic [2:0]    rr_d     [NP];
    logic [CW-1:0] credit_q [NP];
    logic [NP-1:0] send;
    logic [2:0]    src      [NP];

    logic [NP*FLIT_W-1:0] out_flit_q;
    logic [NP-1:0]        out_valid_q;
    logic [NP-1:0]        in_cr_q;

    function automatic logic [2:0] route(input flit_t f,
                                         input logic [COORD_W-1:0] px,
                                         input logic [COORD_W-1:0] py);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = f[FLIT_W-3 -: COORD_W];
        dy = f[FLIT_W-3-COORD_W -: COORD_W];
        if (dx > px)      return 3'd2;
        else if (dx < px) return 3'd4;
        else if (dy > py) return 3'd1;
        else if (dy < py) return 3'd3;
        else              return 3'd0;
    endfunction

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            front[p] = mem_q[p][rd_ptr_q[p]];
            empty[p] = (cnt_q[p] == '0);
            full[p]  = (cnt_q[p] == (AW+1)'(FIFO_DEPTH));
            wr_en[p] = ports.in_valid[p] && !full[p];
        end
    end

    // An input already holding an output may not request a second one.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            owns[p] = 1'b0;
            req[p]  = '0;
        end
        for (int o = 0; o < NP; o++) begin
            for (int p = 0; p < NP; p++) begin
                if (lock_q[o] && owner_q[o] == 3'(p)) owns[p] = 1'b1;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (!empty[p] && front[p][FLIT_W-2] && !owns[p])
                req[p][route(front[p], pos_x, pos_y)] = 1'b1;
        end
    end

    always_comb begin : alloc
        logic found;
        int   win;
        int   idx;
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            send[o]    = 1'b0;
            src[o]     = 3'd0;
            lock_d[o]  = lock_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
        end
        for (int o = 0; o < NP; o++) begin
            found = 1'b0;
            win   = 0;
            idx   = 0;
            if (lock_q[o]) begin
                if (!empty[owner_q[o]] && credit_q[o] != '0) begin
                    send[o] = 1'b1;
                    src[o]  = owner_q[o];
                    if (front[owner_q[o]][FLIT_W-1]) lock_d[o] = 1'b0;
                end
            end else begin
                for (int k = 0; k < NP; k++) begin
                    idx = (int'(rr_q[o]) + k) % NP;
                    if (!found && req[idx][o]) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found && credit_q[o] != '0) begin
                    send[o] = 1'b1;
                    src[o]  = 3'(win);
                    rr_d[o] = (win == NP-1) ? 3'd0 : 3'(win + 1);
                    if (!front[win][FLIT_W-1]) begin
                        lock_d[o]  = 1'b1;
                        owner_d[o] = 3'(win);
                    end
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (send[o]) pop[src[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (wr_en[p]) mem_q[p][wr_ptr_q[p]] <= ports.in_flit[p*FLIT_W +: FLIT_W];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                owner_q[i]  <= '0;
                rr_q[i]     <= '0;
                credit_q[i] <= CW'(CREDITS);
            end
            lock_q      <= '0;
            out_flit_q  <= '0;
            out_valid_q <= '0;
            in_cr_q     <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (wr_en[p]) wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
                if (pop[p])   rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
                cnt_q[p] <= cnt_q[p] + {{AW{1'b0}}, wr_en[p]} - {{AW{1'b0}}, pop[p]};
            end
            for (int o = 0; o < NP; o++) begin
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
                // A credit returned at a full counter is discarded.
                if (send[o] && !ports.out_credit_in[o])
                    credit_q[o] <= credit_q[o] - CW'(1);
                else if (!send[o] && ports.out_credit_in[o] && credit_q[o] != CW'(CREDITS))
                    credit_q[o] <= credit_q[o] + CW'(1);
                if (send[o]) out_flit_q[o*FLIT_W +: FLIT_W] <= front[src[o]];
            end
            lock_q      <= lock_d;
            out_valid_q <= send;
            in_cr_q     <= pop;
        end
    end

    assign ports.out_flit      = out_flit_q;
    assign ports.out_valid     = out_valid_q;
    assign ports.in_credit_out = in_cr_q;

`ifdef ROUTER_ERR_EN
    logic [9:0]    err_q;
    logic [NP-1:0] fifo_ovf;
    logic [NP-1:0] cred_ovf;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            fifo_ovf[i] = ports.in_valid[i] && full[i];
            cred_ovf[i] = ports.out_credit_in[i] && !send[i] && credit_q[i] == CW'(CREDITS);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) err_q <= '0;
        else     err_q <= err_q | {cred_ovf, fifo_ovf};
    end

    assign err = err_q;
`else
    assign err = '0;
`endif
endmodule

// File: tb/tb_router_param.sv
// Scoreboard bench for router_param at node (1,1): expected flits queued per output, checked by a negedge monitor.
module tb_router_param;
    localparam int FW = 22;
`ifdef ROUTER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] pos_x = 2'd1;
    logic [1:0] pos_y = 2'd1;
    logic [9:0] err;

    router_param_if #(.FLIT_W(FW)) rif();

    router_param #(.DATA_W(16), .COORD_W(2), .FIFO_DEPTH(4), .CREDITS(4)) dut (
        .clk   (clk),
        .RST   (RST),
        .pos_x (pos_x),
        .pos_y (pos_y),
        .ports (rif),
        .err   (err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            out_cnt [5] = '{default: 0};
    int            east_cyc [$];
    logic [FW-1:0] exp_q [5][$];
    logic [FW-1:0] mon_exp;
    logic          auto_cred = 1'b1;
    logic [4:0]    man_cred = 5'b0;
    int            base;
    logic [FW-1:0] wflit;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic t, input logic h, input logic [1:0] dx,
                                         input logic [1:0] dy, input logic [15:0] pl);
        return {t, h, dx, dy, pl};
    endfunction

    task automatic put(input int p, input logic [FW-1:0] f, input int o);
        rif.in_flit[p*FW +: FW] = f;
        rif.in_valid[p] = 1'b1;
        if (o >= 0) exp_q[o].push_back(f);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        rif.in_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops the scoreboard on every out_valid and plays the downstream credit source.
    always @(negedge clk) begin
        if (RST) begin
            rif.out_credit_in = '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (rif.out_valid[o]) begin
                    out_cnt[o]++;
                    if (o == 2) east_cyc.push_back(cyc);
                    if (exp_q[o].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out%0d: got %h expected nothing", o, rif.out_flit[o*FW +: FW]);
                    end else begin
                        mon_exp = exp_q[o].pop_front();
                        chk($sformatf("out%0d_flit", o), 32'(rif.out_flit[o*FW +: FW]), 32'(mon_exp));
                    end
                end
            end
            if (rif.out_valid != '0)
                chk("credit_pulse_count", $countones(rif.in_credit_out), $countones(rif.out_valid));
            rif.out_credit_in = (auto_cred ? rif.out_valid : 5'b0) | man_cred;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rif.in_flit  = '0;
        rif.in_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(rif.out_valid), 32'h0);
        chk("rst_out_flit_nz", 32'(rif.out_flit != '0), 32'h0);
        chk("rst_in_credit", 32'(rif.in_credit_out), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        RST = 1'b0;
        idle(2);

        // Single head+tail Local -> East, one-cycle latency
        put(0, mk(1'b1, 1'b1, 2'd3, 2'd1, 16'hA001), 2);
        tick();
        @(posedge clk); #1;
        chk("lat_out_valid", 32'(rif.out_valid), 32'h04);
        chk("lat_in_credit", 32'(rif.in_credit_out), 32'h01);
        chk("lat_flit", 32'(rif.out_flit[2*FW +: FW]), 32'(mk(1'b1, 1'b1, 2'd3, 2'd1, 16'hA001)));
        idle(4);

        // Routes to Local, South, West
        put(4, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hB004), 0);
        put(1, mk(1'b1, 1'b1, 2'd1, 2'd0, 16'hB001), 3);
        put(0, mk(1'b1, 1'b1, 2'd0, 2'd2, 16'hB000), 4);
        tick();
        idle(4);

        // Round-robin on Local: 1,3,4,1,3,4
        put(1, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hC001), 0);
        put(3, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hC003), 0);
        put(4, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hC004), 0);
        tick();
        put(1, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hC011), 0);
        put(3, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hC013), 0);
        put(4, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hC014), 0);
        tick();
        idle(8);

        // Wormhole lock: North 3-flit packet to East blocks West head
        east_cyc.delete();
        put(1, mk(1'b0, 1'b1, 2'd3, 2'd0, 16'hD001), 2);
        tick();
        wflit = mk(1'b1, 1'b1, 2'd3, 2'd1, 16'hD004);
        put(1, mk(1'b0, 1'b0, 2'd0, 2'd0, 16'hD002), 2);
        put(4, wflit, -1);
        tick();
        put(1, mk(1'b1, 1'b0, 2'd0, 2'd0, 16'hD003), 2);
        exp_q[2].push_back(wflit);
        tick();
        idle(6);
        chk("lock_east_count", east_cyc.size(), 4);
        if (east_cyc.size() == 4) begin
            chk("lock_pkt_contig", east_cyc[2] - east_cyc[0], 2);
            chk("lock_west_next", east_cyc[3] - east_cyc[2], 1);
        end

        // Credit exhaustion on East
        auto_cred = 1'b0;
        base = out_cnt[2];
        for (int k = 0; k < 6; k++) begin
            put(0, mk(1'b1, 1'b1, 2'd3, 2'd1, 16'hE000 + 16'(k)), 2);
            tick();
        end
        idle(8);
        chk("credit_stall_count", out_cnt[2] - base, 4);
        man_cred[2] = 1'b1;
        @(posedge clk); #1;
        man_cred[2] = 1'b0;
        idle(5);
        chk("credit_one_more", out_cnt[2] - base, 5);

        // FIFO overflow on blocked South input
        for (int k = 0; k < 5; k++) begin
            put(3, mk(1'b1, 1'b1, 2'd3, 2'd1, 16'hF030 + 16'(k)), -1);
            tick();
        end
        idle(2);
        chk("fifo_ovf_err", 32'(err), ERR_EN ? 32'h008 : 32'h000);

        // Reset mid-packet while Local is locked and presenting a flit
        put(1, mk(1'b0, 1'b1, 2'd1, 2'd1, 16'hF001), 0);
        tick();
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(rif.out_valid), 32'h01);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rif.out_valid), 32'h0);
        chk("async_rst_flit_nz", 32'(rif.out_flit != '0), 32'h0);
        chk("async_rst_in_credit", 32'(rif.in_credit_out), 32'h0);
        chk("async_rst_err", 32'(err), 32'h0);
        for (int o = 0; o < 5; o++) exp_q[o].delete();
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
        idle(2);

        // After reset: credits back to 4, locks and FIFOs cleared
        base = out_cnt[2];
        put(4, mk(1'b1, 1'b1, 2'd1, 2'd1, 16'hA104), 0);
        for (int k = 0; k < 6; k++) begin
            put(0, mk(1'b1, 1'b1, 2'd3, 2'd1, 16'hA200 + 16'(k)), 2);
            tick();
        end
        idle(8);
        chk("post_rst_credits", out_cnt[2] - base, 4);

        // Extra credit on an idle output at full count
        man_cred[1] = 1'b1;
        @(posedge clk); #1;
        man_cred[1] = 1'b0;
        idle(2);
        chk("credit_ovf_err", 32'(err), ERR_EN ? 32'h040 : 32'h000);

        man_cred[2] = 1'b1;
        idle(2);
        man_cred[2] = 1'b0;
        idle(6);
        chk("post_rst_all_sent", out_cnt[2] - base, 6);
        for (int o = 0; o < 5; o++)
            chk($sformatf("pending_out%0d", o), exp_q[o].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
